// File: rtl/act_pingpong_mem.sv
// Ping-pong activation store: producer fills one bank while consumer reads the other.
// Read latency 1 cycle; banks change hands via wr_commit / rd_release, wr_ready / rd_avail gate access.
module act_pingpong_mem #(
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 64,
  parameter int ADDR_W        = 16,
  parameter int RELU_ON_WRITE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              relu_en,
  input  logic              wr_commit,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_release,
  output logic              rd_avail,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              err_oob,
  output logic              err_proto
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [2][DEPTH];
  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_err_oob;
  logic              r_err_proto;

  logic              w_wr_ready;
  logic              w_rd_avail;
  logic              w_wr_inb;
  logic              w_rd_inb;
  logic              w_wr_do;
  logic              w_rd_do;
  logic              w_commit;
  logic              w_release;
  logic              w_relu;
  logic [DATA_W-1:0] w_wr_val;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [1:0]        w_full_nxt;
  logic              w_oob_evt;
  logic              w_proto_evt;

  assign w_wr_ready = ~r_full[r_wr_bank];
  assign w_rd_avail = r_full[r_rd_bank];
  assign w_wr_inb   = ({1'b0, wr_addr} < LP_DEPTH);
  assign w_rd_inb   = ({1'b0, rd_addr} < LP_DEPTH);
  assign w_wr_do    = wr_en & w_wr_ready & w_wr_inb;
  assign w_rd_do    = rd_en & w_rd_avail & w_rd_inb;
  assign w_commit   = wr_commit & w_wr_ready;
  assign w_release  = rd_release & w_rd_avail;
  assign w_wr_idx   = wr_addr[IDX_W-1:0];
  assign w_rd_idx   = rd_addr[IDX_W-1:0];

  assign w_relu   = (RELU_ON_WRITE != 0) & relu_en & wr_data[DATA_W-1];
  assign w_wr_val = w_relu ? '0 : wr_data;

  assign w_oob_evt   = (wr_en & ~w_wr_inb) | (rd_en & ~w_rd_inb);
  assign w_proto_evt = ((wr_en | wr_commit) & ~w_wr_ready) |
                       ((rd_en | rd_release) & ~w_rd_avail);

  // Commit only touches an empty flag and release only a full one, so both can apply at once.
  always_comb begin
    w_full_nxt = r_full;
    if (w_commit)  w_full_nxt[r_wr_bank] = 1'b1;
    if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_wr_do) r_mem[r_wr_bank][w_wr_idx] <= w_wr_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full      <= 2'b00;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_err_oob   <= 1'b0;
      r_err_proto <= 1'b0;
    end else begin
      r_full     <= w_full_nxt;
      r_rd_valid <= w_rd_do;
      if (w_commit)    r_wr_bank   <= ~r_wr_bank;
      if (w_release)   r_rd_bank   <= ~r_rd_bank;
      if (w_rd_do)     r_rd_data   <= r_mem[r_rd_bank][w_rd_idx];
      if (w_oob_evt)   r_err_oob   <= 1'b1;
      if (w_proto_evt) r_err_proto <= 1'b1;
    end
  end

  assign wr_ready  = w_wr_ready;
  assign rd_avail  = w_rd_avail;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign wr_bank   = r_wr_bank;
  assign rd_bank   = r_rd_bank;
  assign err_oob   = r_err_oob;
  assign err_proto = r_err_proto;

endmodule

// File: doc/act_pingpong_mem.md
Name: act_pingpong_mem

Overview:
Double-buffered (ping-pong) activation memory placed between two network layers. The producer layer fills one bank while the consumer layer reads the other. Banks change hands through explicit commit and release handshakes. It generalises the single-bank activation store with parametrised width and depth, registered reads, optional ReLU-on-write, and out-of-range and protocol error flags.

Parameters:
DATA_W, 32, word width in bits (two's-complement activations)
DEPTH, 64, words per bank; need not be a power of two
ADDR_W, 16, address port width; must satisfy 2^ADDR_W >= DEPTH
RELU_ON_WRITE, 0, 1 = clamp negative write data to 0 when relu_en=1; 0 = relu_en ignored

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe into current write bank
wr_addr  in  ADDR_W  write word address
wr_data  in  DATA_W  write data
relu_en  in  1  apply ReLU to wr_data (only if RELU_ON_WRITE=1)
wr_commit  in  1  pulse: write bank complete, hand to consumer
wr_ready  out  1  current write bank free for writing
rd_en  in  1  read strobe from current read bank
rd_addr  in  ADDR_W  read word address
rd_data  out  DATA_W  registered read data
rd_valid  out  1  rd_data valid this cycle
rd_release  in  1  pulse: consumer finished with read bank
rd_avail  out  1  current read bank holds committed data
wr_bank  out  1  index of the bank currently written
rd_bank  out  1  index of the bank currently read
err_oob  out  1  sticky: an access had address >= DEPTH
err_proto  out  1  sticky: commit/write while !wr_ready, or read/release while !rd_avail

Behaviour:
- State: full[1:0] flags, wr_bank and rd_bank pointers, memory of 2*DEPTH words. Memory contents are not reset.
- Reset (async assert, sync release): full=00, wr_bank=0, rd_bank=0, rd_data=0, rd_valid=0, err_oob=0, err_proto=0.
- wr_ready = ~full[wr_bank]; rd_avail = full[rd_bank]. Both are combinational from registers.
- Write: wr_en & wr_ready & wr_addr<DEPTH writes at the clock edge.
  - Stored value is (RELU_ON_WRITE & relu_en & wr_data[DATA_W-1]) ? 0 : wr_data.
  - If wr_addr>=DEPTH: no write, err_oob<=1.
  - If wr_en & !wr_ready: no write, err_proto<=1.
- Commit: wr_commit & wr_ready sets full[wr_bank] and toggles wr_bank. wr_commit & !wr_ready is ignored and sets err_proto.
- Read: rd_en & rd_avail & rd_addr<DEPTH gives rd_data = mem[rd_bank][rd_addr] and rd_valid=1 on the next cycle (latency 1).
  - Otherwise rd_valid=0 next cycle and rd_data holds its last value.
  - rd_addr>=DEPTH sets err_oob. rd_en & !rd_avail sets err_proto.
- Release: rd_release & rd_avail clears full[rd_bank] and toggles rd_bank. rd_release & !rd_avail is ignored and sets err_proto.
- A read issued in the same cycle as rd_release uses the pre-release bank. The next read uses the toggled bank.
- Simultaneous commit and release in one cycle are both honoured. They always target different bank flags: commit needs the flag clear, release needs it set.
- Write and commit in the same cycle: the write lands in the committing bank.
- Both banks full: wr_ready=0 until a release. Both banks empty: rd_avail=0.
- Pointers wrap 1->0. No ordering loss: banks are consumed in commit order.
- err_* flags clear only on reset.

Test Plan:
- Reset, write addr 0..63 with value addr+1, commit -> wr_ready=1, wr_bank=1, rd_avail=1, rd_bank=0. Read addr 5 -> rd_data=6 with rd_valid exactly 1 cycle after rd_en.
- Fill and commit bank 0, then bank 1 -> wr_ready=0. Write to addr 3 -> memory unchanged, err_proto=1. rd_release -> wr_ready=1 and writes proceed to bank 0.
- Same cycle wr_commit (bank 1) and rd_release (bank 0) -> next cycle full=10→ rd_bank=1, wr_bank=0, rd_avail=1, wr_ready=1.
- RELU_ON_WRITE=1, relu_en=1, write 0xFFFF_FFF0 at addr 7 and 0x0000_0010 at addr 8 -> reads return 0 and 0x10. With relu_en=0, addr 7 reads 0xFFFF_FFF0.
- Write addr 64 and read addr 70 with DEPTH=64 -> no memory change, rd_valid=0, err_oob=1 and still 1 after 10 idle cycles.
- Assert rst_n low mid-read with rd_valid=1 -> immediately rd_valid=0, rd_data=0, full=00, pointers 0, error flags 0.
